// File: rtl/module_struct_packer.sv
// Packs a stream of 4-bit nibbles into 16-bit words {part1, part2, part3} and
// hands each word off through a one-entry output register with its member sum.
module module_struct_packer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_nib_valid,
  input  logic [3:0]  i_nib,
  output logic        o_nib_ready,
  input  logic        i_flush,
  output logic        o_pkt_valid,
  input  logic        i_pkt_ready,
  output logic [15:0] o_packed_data,
  output logic [7:0]  o_member_sum,
  output logic [7:0]  o_pkt_count
);

  typedef enum logic [1:0] {
    S_P1  = 2'd0,
    S_P2H = 2'd1,
    S_P2L = 2'd2,
    S_P3  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  part1, part1_nxt;
  logic [7:0]  part2, part2_nxt;

  logic        nib_hs;
  logic        pkt_hs;
  logic        load;
  logic [15:0] word;
  logic [7:0]  word_sum;

  // Only the final nibble needs somewhere to go; earlier nibbles land in the
  // partial fields, so the source stalls only when the held word cannot leave.
  assign o_nib_ready = !((state == S_P3) && o_pkt_valid && !i_pkt_ready);

  assign nib_hs = i_nib_valid && o_nib_ready;
  assign pkt_hs = o_pkt_valid && i_pkt_ready;
  assign load   = nib_hs && !i_flush && (state == S_P3);

  // part3 is the nibble arriving in S_P3; it goes straight into the output word.
  assign word     = {part1, part2, i_nib};
  assign word_sum = {4'b0000, part1} + part2 + {4'b0000, i_nib};

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    part1_nxt = part1;
    part2_nxt = part2;
    if (i_flush) begin
      state_nxt = S_P1;
      part1_nxt = 4'h0;
      part2_nxt = 8'h00;
    end else if (nib_hs) begin
      case (state)
        S_P1: begin
          part1_nxt = i_nib;
          state_nxt = S_P2H;
        end
        S_P2H: begin
          part2_nxt[7:4] = i_nib;
          state_nxt      = S_P2L;
        end
        S_P2L: begin
          part2_nxt[3:0] = i_nib;
          state_nxt      = S_P3;
        end
        S_P3: begin
          state_nxt = S_P1;
        end
        default: begin
          state_nxt = S_P1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_P1;
      part1 <= 4'h0;
      part2 <= 8'h00;
    end else begin
      state <= state_nxt;
      part1 <= part1_nxt;
      part2 <= part2_nxt;
    end
  end

  // NOTE: the output data register is reset as well, so a reset discards a
  // pending word and the outputs read as zero rather than stale data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pkt_valid   <= 1'b0;
      o_packed_data <= 16'h0000;
      o_member_sum  <= 8'h00;
    end else if (load) begin
      o_pkt_valid   <= 1'b1;
      o_packed_data <= word;
      o_member_sum  <= word_sum;
    end else if (pkt_hs) begin
      o_pkt_valid   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pkt_count <= 8'h00;
    end else if (pkt_hs) begin
      o_pkt_count <= o_pkt_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_module_struct_packer.sv
// Directed bench for module_struct_packer: a small nibble model pushes expected
// words into a scoreboard, popped and compared at each packet handshake.
module tb_module_struct_packer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_nib_valid;
  logic [3:0]  i_nib;
  logic        o_nib_ready;
  logic        i_flush;
  logic        o_pkt_valid;
  logic        i_pkt_ready;
  logic [15:0] o_packed_data;
  logic [7:0]  o_member_sum;
  logic [7:0]  o_pkt_count;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  sum;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         m_phase  = 0;
  logic [3:0] m_p1     = 4'h0;
  logic [7:0] m_p2     = 8'h00;

  module_struct_packer dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_nib_valid   (i_nib_valid),
    .i_nib         (i_nib),
    .o_nib_ready   (o_nib_ready),
    .i_flush       (i_flush),
    .o_pkt_valid   (o_pkt_valid),
    .i_pkt_ready   (i_pkt_ready),
    .o_packed_data (o_packed_data),
    .o_member_sum  (o_member_sum),
    .o_pkt_count   (o_pkt_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inspect the pre-edge handshakes, update the model and
  // scoreboard, then advance to just after the next rising edge.
  task automatic tick();
    exp_t e;
    logic [7:0] s;
    #1;
    if (o_pkt_valid && i_pkt_ready) begin
      check("sb_nonempty", sb.size(), 1 <= sb.size() ? sb.size() : 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pkt_data", o_packed_data, e.data);
        check("pkt_sum", o_member_sum, e.sum);
      end
    end
    if (i_flush) begin
      m_phase = 0;
      m_p1    = 4'h0;
      m_p2    = 8'h00;
    end else if (i_nib_valid && o_nib_ready) begin
      case (m_phase)
        0: m_p1      = i_nib;
        1: m_p2[7:4] = i_nib;
        2: m_p2[3:0] = i_nib;
        default: begin
          s = 8'(m_p1) + m_p2 + 8'(i_nib);
          e.data = {m_p1, m_p2, i_nib};
          e.sum  = s;
          sb.push_back(e);
        end
      endcase
      m_phase = (m_phase + 1) % 4;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [3:0] n, input logic f = 1'b0);
    i_nib_valid = 1'b1;
    i_nib       = n;
    i_flush     = f;
    tick();
    i_nib_valid = 1'b0;
    i_flush     = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int k = 3; k >= 0; k--) begin
      logic [3:0] n;
      n = w[k*4 +: 4];
      send(n);
    end
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_nib_valid = 1'b0;
    i_nib       = 4'h0;
    i_flush     = 1'b0;
    i_pkt_ready = 1'b1;

    // Reset values
    #12;
    check("rst_valid", o_pkt_valid, 0);
    check("rst_data", o_packed_data, 16'h0000);
    check("rst_sum", o_member_sum, 8'h00);
    check("rst_count", o_pkt_count, 8'h00);
    check("rst_ready", o_nib_ready, 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Basic word, 1-cycle latency, handoff count
    send_word(16'h1234);
    check("w1234_valid", o_pkt_valid, 1);
    check("w1234_data", o_packed_data, 16'h1234);
    check("w1234_sum", o_member_sum, 8'h28);
    tick();
    check("w1234_count", o_pkt_count, 8'd1);
    check("w1234_drained", o_pkt_valid, 0);

    // Sum wraps modulo 256
    send_word(16'hFFFF);
    check("wffff_data", o_packed_data, 16'hFFFF);
    check("wffff_sum", o_member_sum, 8'h1D);
    tick();
    check("wffff_count", o_pkt_count, 8'd2);

    // Continuous stream: one word per four cycles
    for (int w = 0; w < 4; w++) send_word(16'($urandom));
    check("stream_valid", o_pkt_valid, 1);
    tick();
    check("stream_count", o_pkt_count, 8'd6);

    // Back-pressure stalls only the S_P3 nibble; same-cycle pop and load
    i_pkt_ready = 1'b0;
    send_word(16'h1234);
    send(4'hA);
    send(4'hB);
    send(4'hC);
    i_nib_valid = 1'b1;
    i_nib       = 4'hD;
    #1;
    check("bp_ready_low", o_nib_ready, 0);
    tick();
    tick();
    check("bp_hold_data", o_packed_data, 16'h1234);
    check("bp_hold_sum", o_member_sum, 8'h28);
    check("bp_hold_valid", o_pkt_valid, 1);
    i_pkt_ready = 1'b1;
    #1;
    check("bp_ready_high", o_nib_ready, 1);
    tick();
    i_nib_valid = 1'b0;
    check("bp_valid_cont", o_pkt_valid, 1);
    check("bp_abcd_data", o_packed_data, 16'hABCD);
    check("bp_abcd_sum", o_member_sum, 8'hD3);
    tick();
    check("bp_count", o_pkt_count, 8'd8);

    // Flush drops its nibble and leaves the pending word alone
    i_pkt_ready = 1'b0;
    send_word(16'h1234);
    send(4'h5);
    send(4'h6);
    send(4'h7, 1'b1);
    check("fl_pend_data", o_packed_data, 16'h1234);
    check("fl_pend_valid", o_pkt_valid, 1);
    check("fl_pend_count", o_pkt_count, 8'd8);
    send(4'h8);
    send(4'h9);
    send(4'hA);
    i_pkt_ready = 1'b1;
    send(4'hB);
    check("fl_89ab_data", o_packed_data, 16'h89AB);
    check("fl_89ab_sum", o_member_sum, 8'hAD);
    tick();
    check("fl_count", o_pkt_count, 8'd10);

    // Flush coinciding with the S_P3 nibble loads nothing
    send(4'h1);
    send(4'h2);
    send(4'h3);
    send(4'h4, 1'b1);
    check("fl_p3_noload", o_pkt_valid, 0);
    send_word(16'h5678);
    check("fl_p3_data", o_packed_data, 16'h5678);
    check("fl_p3_sum", o_member_sum, 8'h74);
    tick();

    // Flush without a nibble
    send(4'h1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    send_word(16'h2345);
    check("fl_idle_data", o_packed_data, 16'h2345);
    check("fl_idle_sum", o_member_sum, 8'h3B);
    tick();
    check("fl_idle_count", o_pkt_count, 8'd12);

    // Asynchronous reset mid-assembly with a word pending
    i_pkt_ready = 1'b0;
    send_word(16'h1234);
    send(4'h5);
    send(4'h6);
    send(4'h7);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("ar_valid", o_pkt_valid, 0);
    check("ar_data", o_packed_data, 16'h0000);
    check("ar_sum", o_member_sum, 8'h00);
    check("ar_count", o_pkt_count, 8'h00);
    check("ar_ready", o_nib_ready, 1);
    sb.delete();
    m_phase = 0;
    m_p1    = 4'h0;
    m_p2    = 8'h00;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    i_pkt_ready = 1'b1;
    send_word(16'h1234);
    check("ar_post_data", o_packed_data, 16'h1234);
    check("ar_post_sum", o_member_sum, 8'h28);
    tick();
    check("ar_post_count", o_pkt_count, 8'd1);

    // Packet counter wraps after 256 handoffs
    for (int w = 0; w < 254; w++) send_word(16'($urandom));
    tick();
    check("cnt_255", o_pkt_count, 8'd255);
    send_word(16'($urandom));
    tick();
    check("cnt_wrap", o_pkt_count, 8'd0);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
